minimax_mem_arbiter: RTL
========================

// Module: minimax_mem_arbiter
// PURPOSE
//  Shares one 4-bank 512x32 synchronous SRAM (2048 words, 8 kB) between the minimax instruction-fetch port and data port.
//  Data has priority; fetch is protected from starvation. Sub-word stores become a read-modify-write (RMW) sequence.
//  Decodes a full-word store to EXIT_ADDR as the simulation/system exit register. Sits between core and SRAM banks.
// PARAMETERS
//  PC_BITS     13            fetch address width (byte address)
//  BANK_WORDS  512           words per bank; bank index = addr[12:11], word = addr[10:2]
//  STARVE_MAX  4             consecutive fetch denials before fetch is forced (guard build only)
//  EXIT_ADDR   32'hFFFFFFFC  exit-register address
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  i_req       in   1       fetch request; held with i_addr until i_gnt
//  i_addr      in   PC_BITS fetch byte address; bit1 selects halfword
//  i_gnt       out  1       fetch accepted this cycle (combinational)
//  i_rvalid    out  1       i_rdata valid (cycle after i_gnt)
//  i_rdata     out  16      fetched halfword
//  d_req       in   1       data request; held with d_addr/d_wmask/d_wdata until d_gnt
//  d_addr      in   32      data byte address (word aligned)
//  d_wmask     in   4       byte write enables; 0 = read
//  d_wdata     in   32      store data
//  d_gnt       out  1       data accepted this cycle (combinational)
//  d_rvalid    out  1       d_rdata valid (cycle after a read d_gnt)
//  d_rdata     out  32      load data
//  mem_en      out  4       one-hot bank enable (combinational)
//  mem_addr    out  9       word address within bank
//  mem_wen     out  1       full-word write
//  mem_wdata   out  32      write data
//  mem_rdata   in   128     bank read data {bank3,bank2,bank1,bank0}, valid cycle after access
//  exit_valid  out  1       one-cycle pulse on exit-register store
//  exit_code   out  32      value stored to exit register (held)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, i_rvalid=d_rvalid=exit_valid=0, exit_code=0, starve count=0;
//   i_gnt, d_gnt, mem_en, mem_wen forced 0 while reset_n=0.
//  States: IDLE, RMW. At most one SRAM access per cycle.
//  IDLE arbitration: d_req wins over i_req, unless starve guard fires (see CONFIGURATION).
//   Data read: d_gnt=1, SRAM read issued; d_rvalid=1 next cycle, d_rdata = mem_rdata slice of registered bank.
//   Data write, d_wmask=4'hF: d_gnt=1, mem_wen=1, mem_wdata=d_wdata; no rvalid.
//   Data write, partial mask: d_gnt=0, read target word, go RMW. RMW: mem_wen=1, mem_wdata = masked merge
//    (byte k from d_wdata if d_wmask[k], else from mem_rdata), d_gnt=1, back to IDLE. i_gnt=0 in both cycles.
//   Fetch: i_gnt=1, read word i_addr[12:2]; next cycle i_rvalid=1, i_rdata = registered i_addr[1] ? [31:16] : [15:0].
//  Out-of-range (d_addr[31:13]!=0): mem_en=0. Read: granted, d_rvalid next cycle with d_rdata=0.
//   Write to EXIT_ADDR with mask 4'hF: granted, exit_valid=1 next cycle, exit_code<=d_wdata. Other writes: granted, dropped.
//   Partial write to out-of-range address: granted in IDLE, no RMW, dropped.
//  Simultaneous i_req/d_req: only the winner gets gnt; loser must hold request.
//  rvalid of the previous access and a new gnt may coincide (back-to-back, throughput 1/cycle).
//  Reset asserted during RMW: write aborted, SRAM untouched, state IDLE.
// CONFIGURATION
//  MINIMAX_ARB_STARVE_GUARD_EN defined: counter increments each cycle i_req=1 and i_gnt=0, clears on i_gnt.
//   When count>=STARVE_MAX in IDLE, fetch wins over d_req for that cycle. Counter saturates at STARVE_MAX.
//   Never preempts an RMW in progress.
//  Undefined: strict data priority, no counter; fetch may starve indefinitely.
// TESTING
//  1 Reset: reset_n=0 mid-traffic -> all gnt/rvalid/exit_valid/mem_en 0 immediately, exit_code=0.
//  2 Fetch 0x0806, bank1 word 1 = 32'hCAFE_1234 -> i_gnt, next cycle i_rvalid, i_rdata=16'hCAFE.
//  3 Word 0x10=32'h11223344; store d_wmask=4'b0010, d_wdata=32'hxxxxAAxx -> two cycles, 32'h1122AA44 written, then reads back.
//  4 i_req+d_req read together, no guard -> d_gnt first, i_gnt next cycle. Both rdata correct.
//  5 Guard: d_req held continuously, STARVE_MAX=4 -> i_gnt on 5th cycle of i_req, count cleared.
//  6 Store 32'h0 to 0xFFFFFFFC mask F -> exit_valid pulse, exit_code=0, no mem_en. Read 0x4000_0000 -> d_rdata=0.

Source files
------------

// File: rtl/minimax_mem_arbiter.sv
// -----------------------------------------------------------------------------
// minimax_mem_arbiter
//   Shares one 4-bank 512x32 synchronous SRAM (2048 words) between the minimax
//   instruction-fetch port and data port. Data has priority over fetch. Sub-word
//   stores become a two-cycle read-modify-write. A full-word store to EXIT_ADDR
//   is decoded as the exit register. Any other address with d_addr[31:13] != 0
//   never reaches the SRAM.
//
//   Optional build macro: MINIMAX_ARB_STARVE_GUARD_EN
//     When defined, a fetch that has been denied STARVE_MAX cycles in a row
//     wins over data for one cycle. The guard never preempts an RMW.
//     When undefined, data priority is strict.
//
// Ports
//   clk, reset_n            clock and asynchronous active-low reset
//   i_req/i_addr            fetch request and byte address, held until i_gnt
//   i_gnt                   fetch accepted (combinational)
//   i_rvalid/i_rdata        fetched halfword, valid the cycle after i_gnt
//   d_req/d_addr/d_wmask/d_wdata
//                           data request, held until d_gnt; d_wmask=0 is a read
//   d_gnt                   data accepted (combinational)
//   d_rvalid/d_rdata        load data, valid the cycle after a read d_gnt
//   mem_en/mem_addr/mem_wen/mem_wdata
//                           SRAM bank enables (one-hot), word address, write
//   mem_rdata               {bank3,bank2,bank1,bank0}, valid the cycle after access
//   exit_valid/exit_code    exit-register store pulse and held value
// -----------------------------------------------------------------------------
module minimax_mem_arbiter #(
  parameter int unsigned PC_BITS    = 13,
  parameter int unsigned BANK_WORDS = 512,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] EXIT_ADDR  = 32'hFFFFFFFC
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_req,
  input  logic [PC_BITS-1:0] i_addr,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [15:0]        i_rdata,
  input  logic               d_req,
  input  logic [31:0]        d_addr,
  input  logic [3:0]         d_wmask,
  input  logic [31:0]        d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,
  output logic [3:0]         mem_en,
  output logic [8:0]         mem_addr,
  output logic               mem_wen,
  output logic [31:0]        mem_wdata,
  input  logic [127:0]       mem_rdata,
  output logic               exit_valid,
  output logic [31:0]        exit_code
);

  typedef enum logic {IDLE, RMW} state_t;

  state_t      r_state, w_next;
  logic        r_i_rvalid, r_d_rvalid, r_d_oor, r_half, r_exit_valid;
  logic [1:0]  r_bank;
  logic [31:0] r_exit_code;

  logic        w_d_oor, w_d_wr, w_d_full, w_d_rd, w_exit, w_force_fetch;
  logic [1:0]  w_d_bank, w_i_bank;
  logic [8:0]  w_d_word, w_i_word;
  logic [31:0] w_d_slice, w_r_slice, w_merge;
  logic        w_unused;

  assign w_d_oor  = |d_addr[31:13];
  assign w_d_wr   = |d_wmask;
  assign w_d_full = (d_wmask == 4'hF);
  assign w_d_bank = d_addr[12:11];
  assign w_d_word = d_addr[10:2];
  assign w_i_bank = i_addr[PC_BITS-1 -: 2];
  assign w_i_word = i_addr[PC_BITS-3:2];

  // Data address is held through RMW, so its bank selects the read-back word.
  assign w_d_slice = mem_rdata[{w_d_bank, 5'd0} +: 32];
  // Bank of the previous cycle's access selects the returned read data.
  assign w_r_slice = mem_rdata[{r_bank, 5'd0} +: 32];

  assign w_unused = &{1'b0, d_addr[1:0], i_addr[0], (BANK_WORDS == 0), (STARVE_MAX == 0)};

  always_comb begin
    w_merge = w_d_slice;
    for (int unsigned k = 0; k < 4; k++) begin
      if (d_wmask[k]) w_merge[8*k +: 8] = d_wdata[8*k +: 8];
    end
  end

`ifdef MINIMAX_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] r_starve;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (i_gnt) begin
      r_starve <= '0;
    end else if (i_req && (r_starve < CW'(STARVE_MAX))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign w_force_fetch = (r_starve >= CW'(STARVE_MAX));
`else
  assign w_force_fetch = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = '0;
    mem_addr  = w_d_word;
    mem_wen   = 1'b0;
    mem_wdata = d_wdata;
    w_d_rd    = 1'b0;
    w_exit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req && (!d_req || w_force_fetch)) begin
          i_gnt    = 1'b1;
          mem_en   = 4'b0001 << w_i_bank;
          mem_addr = w_i_word;
        end else if (d_req) begin
          if (w_d_oor) begin
            // Never touches the SRAM; reads return zero, writes are dropped
            // except the full-word exit-register store.
            d_gnt  = 1'b1;
            w_d_rd = !w_d_wr;
            w_exit = w_d_full && (d_addr == EXIT_ADDR);
          end else if (!w_d_wr) begin
            d_gnt  = 1'b1;
            mem_en = 4'b0001 << w_d_bank;
            w_d_rd = 1'b1;
          end else if (w_d_full) begin
            d_gnt   = 1'b1;
            mem_en  = 4'b0001 << w_d_bank;
            mem_wen = 1'b1;
          end else begin
            mem_en = 4'b0001 << w_d_bank;
            w_next = RMW;
          end
        end
      end
      RMW: begin
        d_gnt     = 1'b1;
        mem_en    = 4'b0001 << w_d_bank;
        mem_wen   = 1'b1;
        mem_wdata = w_merge;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (!reset_n) begin
      i_gnt   = 1'b0;
      d_gnt   = 1'b0;
      mem_en  = '0;
      mem_wen = 1'b0;
      w_d_rd  = 1'b0;
      w_exit  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_d_oor      <= 1'b0;
      r_half       <= 1'b0;
      r_bank       <= '0;
      r_exit_valid <= 1'b0;
      r_exit_code  <= '0;
    end else begin
      r_state      <= w_next;
      r_i_rvalid   <= i_gnt;
      r_d_rvalid   <= w_d_rd;
      r_exit_valid <= w_exit;
      if (i_gnt) begin
        r_bank <= w_i_bank;
        r_half <= i_addr[1];
      end else if (w_d_rd) begin
        r_bank  <= w_d_bank;
        r_d_oor <= w_d_oor;
      end
      if (w_exit) r_exit_code <= d_wdata;
    end
  end

  assign i_rvalid   = r_i_rvalid;
  assign i_rdata    = r_half ? w_r_slice[31:16] : w_r_slice[15:0];
  assign d_rvalid   = r_d_rvalid;
  assign d_rdata    = r_d_oor ? '0 : w_r_slice;
  assign exit_valid = r_exit_valid;
  assign exit_code  = r_exit_code;

endmodule
